hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline control unit for the 5-stage RV32I core (IF, DE, ALU, MEM, WB). It consumes the load-use indication from the DE-stage forwarding logic, the branch/jump resolution from ALU, the data-memory busy flag and a halt request from MEM. From these it produces per-stage stall and bubble-insert controls, the PC redirect, and stall/flush performance counters. It carries one registered redirect so a taken branch is not lost while instruction fetch is busy.

## Interface
- CNT_W, 32: width of the performance counters.
- SATURATE, 1: 1 means counters saturate at all-ones; 0 means they wrap.

- clk  in  1  core clock
- rstn  in  1  asynchronous reset, active-low
- WaitLoad_1  in  1  load in ALU has a destination register that a DE-stage source reads (load-use)
- ALU_BranchTaken_1  in  1  branch/jump in ALU resolved taken
- ALU_BranchTarget_32  in  32  target address of that branch/jump
- MemBusy_1  in  1  data memory has not completed the MEM-stage access
- IMemBusy_1  in  1  instruction fetch cannot accept a new PC this cycle
- MEM_HaltReq_1  in  1  EBREAK/ECALL in MEM requests halt
- Resume_1  in  1  leave HALT
- IF_Stall_1, DE_Stall_1, ALU_Stall_1, MEM_Stall_1  out  1 each  hold PC / IF-DE / DE-ALU / ALU-MEM register
- DE_Flush_1  out  1  load a bubble into the IF-DE register
- ALU_Flush_1  out  1  load a bubble into the DE-ALU register
- PC_Redirect_1  out  1  PC loads PC_RedirectTarget_32; overrides IF_Stall_1 at the PC
- PC_RedirectTarget_32  out  32  redirect address
- Halted_1  out  1  core halted
- StallCycles  out  CNT_W  count of cycles with IF_Stall_1=1
- FlushCount  out  CNT_W  count of redirects accepted by fetch

## Operation
- States:
  - RUN, REDIR_HOLD, HALT. Reset state is RUN.
  - REDIR_HOLD has an associated register, TgtReg (32 bits, reset 0).
- Priority order: rstn low, then MemBusy_1, then state HALT, then MEM_HaltReq_1, then REDIR_HOLD, then ALU_BranchTaken_1, then WaitLoad_1.
- While rstn is low:
  - All four stalls = 1, both flushes = 1.
  - PC_Redirect_1 = 0, Halted_1 = 0, counters = 0.
- MemBusy_1=1 (any state): all four stalls = 1, flushes = 0, and the state is held.
  - In REDIR_HOLD, PC_Redirect_1 stays 1 with TgtReg.
  - In HALT, Halted_1 stays 1.
- HALT:
  - All stalls = 1, flushes = 0, Halted_1 = 1.
  - Resume_1 moves the state to RUN on the next cycle.
- MEM_HaltReq_1 in RUN: all stalls = 1, the state goes to HALT.
  - Any same-cycle branch or WaitLoad is ignored (the younger instruction is frozen).
- ALU_BranchTaken_1 in RUN:
  - Outputs: PC_Redirect_1 = 1, PC_RedirectTarget_32 = ALU_BranchTarget_32, DE_Flush_1 = 1, ALU_Flush_1 = 1.
  - All stalls = 0; WaitLoad_1 is ignored.
  - If IMemBusy_1 = 0, the redirect is accepted, FlushCount increments and the state stays RUN.
  - If IMemBusy_1 = 1, TgtReg captures the target and the state goes to REDIR_HOLD.
- REDIR_HOLD:
  - Outputs: PC_Redirect_1 = 1, PC_RedirectTarget_32 = TgtReg, DE_Flush_1 = 1, ALU_Flush_1 = 1, IF_Stall_1 = 1.
  - DE, ALU and MEM stalls = 0.
  - On the first cycle with IMemBusy_1 = 0, FlushCount increments and the state returns to RUN.
- WaitLoad_1 in RUN with no branch:
  - IF_Stall_1 = 1, DE_Stall_1 = 1, ALU_Flush_1 = 1.
  - Other stalls and flushes = 0.
- Otherwise, all control outputs = 0.
- PC_RedirectTarget_32 is 0 whenever PC_Redirect_1 = 0.
- Counters:
  - StallCycles increments on every post-reset cycle with IF_Stall_1 = 1.
  - Both counters saturate or wrap according to SATURATE.

## Timing
- All control outputs are combinational from the current state and inputs, with zero-cycle latency.
- Only the state, TgtReg and the counters are registered.
- A redirect accepted in cycle N loads the PC at the edge ending cycle N.
- A load-use stall costs exactly 1 bubble: WaitLoad_1 drops once the load advances to MEM.
- Counter updates appear one cycle after the qualifying cycle.
- Reset asserted in any state returns the block to RUN immediately (asynchronously) and discards TgtReg.

## Structure
- Shared package rv32_pipe_pkg holds:
  - the state encoding (RUN=2'd0, REDIR_HOLD=2'd1, HALT=2'd2);
  - the bubble/NOP instruction constant 32'h00000013.
- One sub-module, sat_counter (parameters W and SATURATE; inputs inc and clear), instantiated twice.

## Test plan
- WaitLoad_1 pulsed for 1 cycle in RUN -> IF_Stall_1 = 1, DE_Stall_1 = 1, ALU_Flush_1 = 1 for that cycle only; StallCycles increments 0 -> 1.
- ALU_BranchTaken_1 with target 32'h00000100 and IMemBusy_1 = 0 -> PC_Redirect_1 = 1, target 0x100, both flushes = 1; FlushCount = 1; state stays RUN.
- Branch with target 32'h00000200 while IMemBusy_1 = 1 for 3 cycles -> REDIR_HOLD for 3 cycles with target 0x200 and IF_Stall_1 = 1; RUN on the 4th cycle; FlushCount increments once only.
- WaitLoad_1 and ALU_BranchTaken_1 in the same cycle -> redirect behaviour only; DE_Stall_1 = 0.
- MemBusy_1 high for 4 cycles during REDIR_HOLD -> all stalls = 1, PC_Redirect_1 held; state is still REDIR_HOLD after MemBusy_1 falls.
- MEM_HaltReq_1 with a same-cycle branch -> no redirect, HALT next cycle with Halted_1 = 1; Resume_1 -> RUN. Separately, rstn pulsed low mid-HALT -> RUN with counters = 0.

Source files
------------

// File: rtl/rv32_pipe_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pipe_pkg
// Shared definitions for the 5-stage RV32I pipeline control logic.
//   pipe_state_e : hazard controller state encoding
//   NOP_INSTR    : canonical bubble instruction (addi x0, x0, 0)
// ---------------------------------------------------------------------------
package rv32_pipe_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_HOLD = 2'd1,
    HALT       = 2'd2
  } pipe_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that either saturates at all-ones or wraps.
//   clk, rstn : clock, asynchronous active-low reset
//   inc       : count one event this cycle
//   clear     : synchronous clear (wins over inc)
//   count     : current count value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W        = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      if (SATURATE && (&r_count)) begin
        r_count <= r_count;
      end else begin
        r_count <= r_count + W'(1);
      end
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline control unit for the 5-stage RV32I core (IF, DE, ALU, MEM, WB).
// Produces per-stage stall / bubble controls, the PC redirect, and
// stall / flush performance counters.
//   clk, rstn              : clock, asynchronous active-low reset
//   WaitLoad_1             : load-use hazard detected in DE
//   ALU_BranchTaken_1      : branch/jump in ALU resolved taken
//   ALU_BranchTarget_32    : target of that branch/jump
//   MemBusy_1              : data memory access not complete
//   IMemBusy_1             : fetch cannot accept a new PC this cycle
//   MEM_HaltReq_1          : EBREAK/ECALL in MEM requests halt
//   Resume_1               : leave HALT
//   IF/DE/ALU/MEM_Stall_1  : hold PC / IF-DE / DE-ALU / ALU-MEM register
//   DE_Flush_1, ALU_Flush_1: load bubble into IF-DE / DE-ALU register
//   PC_Redirect_1          : PC loads PC_RedirectTarget_32
//   PC_RedirectTarget_32   : redirect address (0 when no redirect)
//   Halted_1               : core halted
//   StallCycles            : cycles with IF_Stall_1 = 1
//   FlushCount             : redirects accepted by fetch
// ---------------------------------------------------------------------------
module hazard_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             WaitLoad_1,
  input  logic             ALU_BranchTaken_1,
  input  logic [31:0]      ALU_BranchTarget_32,
  input  logic             MemBusy_1,
  input  logic             IMemBusy_1,
  input  logic             MEM_HaltReq_1,
  input  logic             Resume_1,
  output logic             IF_Stall_1,
  output logic             DE_Stall_1,
  output logic             ALU_Stall_1,
  output logic             MEM_Stall_1,
  output logic             DE_Flush_1,
  output logic             ALU_Flush_1,
  output logic             PC_Redirect_1,
  output logic [31:0]      PC_RedirectTarget_32,
  output logic             Halted_1,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  pipe_state_e r_state;
  pipe_state_e w_nextState;
  logic [31:0] r_tgtReg;
  logic        w_tgtLoad;
  logic        w_flushInc;

  // State and held redirect target. Reset drops any pending redirect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= RUN;
      r_tgtReg <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_tgtLoad) begin
        r_tgtReg <= ALU_BranchTarget_32;
      end
    end
  end

  // Control decode in strict priority: reset, data-memory busy, HALT,
  // halt request, pending redirect, taken branch, load-use.
  always_comb begin
    w_nextState          = r_state;
    w_tgtLoad            = 1'b0;
    w_flushInc           = 1'b0;
    IF_Stall_1           = 1'b0;
    DE_Stall_1           = 1'b0;
    ALU_Stall_1          = 1'b0;
    MEM_Stall_1          = 1'b0;
    DE_Flush_1           = 1'b0;
    ALU_Flush_1          = 1'b0;
    PC_Redirect_1        = 1'b0;
    PC_RedirectTarget_32 = '0;
    Halted_1             = 1'b0;

    if (!rstn) begin
      IF_Stall_1  = 1'b1;
      DE_Stall_1  = 1'b1;
      ALU_Stall_1 = 1'b1;
      MEM_Stall_1 = 1'b1;
      DE_Flush_1  = 1'b1;
      ALU_Flush_1 = 1'b1;
      w_nextState = RUN;
    end else if (MemBusy_1) begin
      // Whole pipe frozen; a pending redirect or halt stays visible.
      IF_Stall_1  = 1'b1;
      DE_Stall_1  = 1'b1;
      ALU_Stall_1 = 1'b1;
      MEM_Stall_1 = 1'b1;
      if (r_state == REDIR_HOLD) begin
        PC_Redirect_1        = 1'b1;
        PC_RedirectTarget_32 = r_tgtReg;
      end
      if (r_state == HALT) begin
        Halted_1 = 1'b1;
      end
    end else if (r_state == HALT) begin
      IF_Stall_1  = 1'b1;
      DE_Stall_1  = 1'b1;
      ALU_Stall_1 = 1'b1;
      MEM_Stall_1 = 1'b1;
      Halted_1    = 1'b1;
      if (Resume_1) begin
        w_nextState = RUN;
      end
    end else if (MEM_HaltReq_1) begin
      // The halting instruction is older than anything in ALU/DE, so a
      // same-cycle branch or load-use is simply frozen.
      IF_Stall_1  = 1'b1;
      DE_Stall_1  = 1'b1;
      ALU_Stall_1 = 1'b1;
      MEM_Stall_1 = 1'b1;
      w_nextState = HALT;
    end else if (r_state == REDIR_HOLD) begin
      // Keep presenting the held target until fetch takes it.
      PC_Redirect_1        = 1'b1;
      PC_RedirectTarget_32 = r_tgtReg;
      DE_Flush_1           = 1'b1;
      ALU_Flush_1          = 1'b1;
      IF_Stall_1           = 1'b1;
      if (!IMemBusy_1) begin
        w_flushInc  = 1'b1;
        w_nextState = RUN;
      end
    end else if (ALU_BranchTaken_1) begin
      PC_Redirect_1        = 1'b1;
      PC_RedirectTarget_32 = ALU_BranchTarget_32;
      DE_Flush_1           = 1'b1;
      ALU_Flush_1          = 1'b1;
      if (!IMemBusy_1) begin
        w_flushInc = 1'b1;
      end else begin
        w_tgtLoad   = 1'b1;
        w_nextState = REDIR_HOLD;
      end
    end else if (WaitLoad_1) begin
      IF_Stall_1  = 1'b1;
      DE_Stall_1  = 1'b1;
      ALU_Flush_1 = 1'b1;
    end
  end

  sat_counter #(
    .W        (CNT_W),
    .SATURATE (SATURATE)
  ) u_stallCnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (IF_Stall_1),
    .clear (1'b0),
    .count (StallCycles)
  );

  sat_counter #(
    .W        (CNT_W),
    .SATURATE (SATURATE)
  ) u_flushCnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (w_flushInc),
    .clear (1'b0),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed self-checking bench for hazard_ctrl. Counters are narrowed to
// 4 bits so saturation is reached within the sequence.
// Control vector order: {IF,DE,ALU,MEM stall, DE,ALU flush, redirect, halted}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          rstn;
  logic          WaitLoad_1;
  logic          ALU_BranchTaken_1;
  logic [31:0]   ALU_BranchTarget_32;
  logic          MemBusy_1;
  logic          IMemBusy_1;
  logic          MEM_HaltReq_1;
  logic          Resume_1;
  logic          IF_Stall_1, DE_Stall_1, ALU_Stall_1, MEM_Stall_1;
  logic          DE_Flush_1, ALU_Flush_1;
  logic          PC_Redirect_1;
  logic [31:0]   PC_RedirectTarget_32;
  logic          Halted_1;
  logic [CW-1:0] StallCycles;
  logic [CW-1:0] FlushCount;

  typedef struct {
    string         tag;
    logic [7:0]    ctrl;
    logic [31:0]   tgt;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t          scoreboard[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] mStall;
  logic [CW-1:0] mFlush;

  hazard_ctrl #(.CNT_W(CW), .SATURATE(1'b1)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .WaitLoad_1           (WaitLoad_1),
    .ALU_BranchTaken_1    (ALU_BranchTaken_1),
    .ALU_BranchTarget_32  (ALU_BranchTarget_32),
    .MemBusy_1            (MemBusy_1),
    .IMemBusy_1           (IMemBusy_1),
    .MEM_HaltReq_1        (MEM_HaltReq_1),
    .Resume_1             (Resume_1),
    .IF_Stall_1           (IF_Stall_1),
    .DE_Stall_1           (DE_Stall_1),
    .ALU_Stall_1          (ALU_Stall_1),
    .MEM_Stall_1          (MEM_Stall_1),
    .DE_Flush_1           (DE_Flush_1),
    .ALU_Flush_1          (ALU_Flush_1),
    .PC_Redirect_1        (PC_Redirect_1),
    .PC_RedirectTarget_32 (PC_RedirectTarget_32),
    .Halted_1             (Halted_1),
    .StallCycles          (StallCycles),
    .FlushCount           (FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic checkOutput();
    exp_t       e;
    logic [7:0] obs;
    checks++;
    assert (scoreboard.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=>0");
      return;
    end
    e   = scoreboard.pop_front();
    obs = {IF_Stall_1, DE_Stall_1, ALU_Stall_1, MEM_Stall_1,
           DE_Flush_1, ALU_Flush_1, PC_Redirect_1, Halted_1};
    assert (obs === e.ctrl) else begin
      errors++;
      $error("[TB] FAIL %s_ctrl observed=%b expected=%b", e.tag, obs, e.ctrl);
    end
    checks++;
    assert (PC_RedirectTarget_32 === e.tgt) else begin
      errors++;
      $error("[TB] FAIL %s_target observed=%h expected=%h", e.tag, PC_RedirectTarget_32, e.tgt);
    end
    checks++;
    assert (StallCycles === e.sc) else begin
      errors++;
      $error("[TB] FAIL %s_stallcnt observed=%0d expected=%0d", e.tag, StallCycles, e.sc);
    end
    checks++;
    assert (FlushCount === e.fc) else begin
      errors++;
      $error("[TB] FAIL %s_flushcnt observed=%0d expected=%0d", e.tag, FlushCount, e.fc);
    end
  endtask

  // Drive one cycle of inputs (called just after a rising edge), queue the
  // expectation, compare at the falling edge, then update the counter model.
  task automatic applyStimulus(input string tag, input logic wl, input logic bt,
                               input logic [31:0] bTgt, input logic mb, input logic imb,
                               input logic hr, input logic rs, input logic [7:0] expCtrl,
                               input logic [31:0] expTgt, input logic accepted);
    exp_t e;
    WaitLoad_1          = wl;
    ALU_BranchTaken_1   = bt;
    ALU_BranchTarget_32 = bTgt;
    MemBusy_1           = mb;
    IMemBusy_1          = imb;
    MEM_HaltReq_1       = hr;
    Resume_1            = rs;
    e.tag  = tag;
    e.ctrl = expCtrl;
    e.tgt  = expTgt;
    e.sc   = mStall;
    e.fc   = mFlush;
    scoreboard.push_back(e);
    @(negedge clk);
    checkOutput();
    if (expCtrl[7]) mStall = satInc(mStall);
    if (accepted)   mFlush = satInc(mFlush);
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    exp_t e;
    e.tag  = tag;
    e.ctrl = 8'b1111_1100;
    e.tgt  = 32'h0;
    e.sc   = '0;
    e.fc   = '0;
    scoreboard.push_back(e);
    checkOutput();
  endtask

  initial begin
    mStall = '0;
    mFlush = '0;
    rstn = 1'b0;
    WaitLoad_1 = 1'b0; ALU_BranchTaken_1 = 1'b0; ALU_BranchTarget_32 = '0;
    MemBusy_1 = 1'b0; IMemBusy_1 = 1'b0; MEM_HaltReq_1 = 1'b0; Resume_1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    rstn = 1'b1;
    @(posedge clk);
    #1;

    //              tag          wl bt target        mb imb hr rs  ctrl          exp target    acc
    applyStimulus("idle0",     0, 0, 32'h0,        0, 0, 0, 0, 8'b0000_0000, 32'h0,        0);
    applyStimulus("loaduse",   1, 0, 32'h0,        0, 0, 0, 0, 8'b1100_0100, 32'h0,        0);
    applyStimulus("idle1",     0, 0, 32'h0,        0, 0, 0, 0, 8'b0000_0000, 32'h0,        0);
    applyStimulus("br100",     0, 1, 32'h100,      0, 0, 0, 0, 8'b0000_1110, 32'h100,      1);
    applyStimulus("idle2",     0, 0, 32'h0,        0, 0, 0, 0, 8'b0000_0000, 32'h0,        0);
    applyStimulus("br200",     0, 1, 32'h200,      0, 1, 0, 0, 8'b0000_1110, 32'h200,      0);
    applyStimulus("hold1",     0, 0, 32'hBAD0,     0, 1, 0, 0, 8'b1000_1110, 32'h200,      0);
    applyStimulus("hold2",     0, 0, 32'hBAD0,     0, 1, 0, 0, 8'b1000_1110, 32'h200,      0);
    applyStimulus("hold3",     0, 0, 32'hBAD0,     0, 0, 0, 0, 8'b1000_1110, 32'h200,      1);
    applyStimulus("run4",      0, 0, 32'h0,        0, 0, 0, 0, 8'b0000_0000, 32'h0,        0);
    applyStimulus("wl_br300",  1, 1, 32'h300,      0, 0, 0, 0, 8'b0000_1110, 32'h300,      1);
    applyStimulus("idle3",     0, 0, 32'h0,        0, 0, 0, 0, 8'b0000_0000, 32'h0,        0);
    applyStimulus("br400",     0, 1, 32'h400,      0, 1, 0, 0, 8'b0000_1110, 32'h400,      0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("mbusy",   0, 0, 32'h0,        1, 0, 0, 0, 8'b1111_0010, 32'h400,      0);
    end
    applyStimulus("hold_acc",  0, 0, 32'h0,        0, 0, 0, 0, 8'b1000_1110, 32'h400,      1);
    applyStimulus("idle4",     0, 0, 32'h0,        0, 0, 0, 0, 8'b0000_0000, 32'h0,        0);
    applyStimulus("haltreq",   1, 1, 32'h500,      0, 0, 1, 0, 8'b1111_0000, 32'h0,        0);
    applyStimulus("halted",    0, 1, 32'h600,      0, 0, 0, 0, 8'b1111_0001, 32'h0,        0);
    applyStimulus("halt_mb",   0, 0, 32'h0,        1, 0, 0, 1, 8'b1111_0001, 32'h0,        0);
    applyStimulus("resume",    0, 0, 32'h0,        0, 0, 0, 1, 8'b1111_0001, 32'h0,        0);
    applyStimulus("run5",      0, 0, 32'h0,        0, 0, 0, 0, 8'b0000_0000, 32'h0,        0);
    applyStimulus("haltreq2",  0, 0, 32'h0,        0, 0, 1, 0, 8'b1111_0000, 32'h0,        0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("halt_sat", 0, 0, 32'h0,       0, 0, 0, 0, 8'b1111_0001, 32'h0,        0);
    end

    // Asynchronous reset in the middle of HALT.
    rstn = 1'b0;
    #1;
    checkReset("reset_halt");
    mStall = '0;
    mFlush = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("after_rst", 0, 0, 32'h0,        0, 0, 0, 0, 8'b0000_0000, 32'h0,        0);
    applyStimulus("br_post",   0, 1, 32'h700,      0, 0, 0, 0, 8'b0000_1110, 32'h700,      1);
    applyStimulus("idle5",     0, 0, 32'h0,        0, 0, 0, 0, 8'b0000_0000, 32'h0,        0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
